// File: rtl/nlc_horner_ctrl.sv
// nlc_horner_ctrl: evaluates a sectioned, normalised Horner polynomial by
// sequencing word operands through an external float multiplier and adder.
module nlc_horner_ctrl #(
  parameter int NCOEF_S0 = 7,
  parameter int NCOEF_S1 = 6,
  parameter int NCOEF_S2 = 6,
  parameter int NCOEF_S3 = 7,
  parameter int XTHRESH  = 44978
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_srdyi,
  input  logic signed [20:0] i_xraw,
  input  logic [31:0]        i_xf,
  output logic               o_rdy,
  output logic               o_srdyo,
  output logic [31:0]        o_y,
  output logic [1:0]         o_sect,
  output logic [2:0]         o_cidx,
  input  logic [31:0]        i_coeff,
  input  logic [31:0]        i_negmean,
  input  logic [31:0]        i_invstd,
  output logic [31:0]        o_mul_x,
  output logic [31:0]        o_mul_y,
  output logic               o_mul_srdyi,
  input  logic [31:0]        i_mul_z,
  input  logic               i_mul_srdyo,
  output logic [31:0]        o_add_x,
  output logic [31:0]        o_add_y,
  output logic               o_add_srdyi,
  input  logic [31:0]        i_add_z,
  input  logic               i_add_srdyo
);
  typedef enum logic [3:0] {
    IDLE, PRE_ADD, PRE_ADD_W, PRE_MUL, PRE_MUL_W,
    H_MUL, H_MUL_W, H_ADD, H_ADD_W, DONE
  } state_t;

  state_t             state, state_n;
  logic [2:0]         k, last;
  logic [31:0]        xf, acc, xn;
  logic signed [31:0] xr;
  logic [1:0]         dec;
  logic               pre_add, pre_mul, h_mul, h_add;

  assign xr  = 32'(i_xraw);
  assign dec = xr <= -XTHRESH ? 2'd0 : xr <= 0 ? 2'd1 : xr <= XTHRESH ? 2'd2 : 2'd3;
  assign last = o_sect == 2'd0 ? 3'(NCOEF_S0 - 1) :
                o_sect == 2'd1 ? 3'(NCOEF_S1 - 1) :
                o_sect == 2'd2 ? 3'(NCOEF_S2 - 1) : 3'(NCOEF_S3 - 1);

  assign pre_add = state inside {PRE_ADD, PRE_ADD_W};
  assign pre_mul = state inside {PRE_MUL, PRE_MUL_W};
  assign h_mul   = state inside {H_MUL, H_MUL_W};
  assign h_add   = state inside {H_ADD, H_ADD_W};

  // Operands are pure functions of state so they stay stable across each wait.
  assign o_rdy       = state == IDLE;
  assign o_srdyo     = state == DONE;
  assign o_cidx      = (h_mul || h_add) ? k : 3'd0;
  assign o_add_x     = pre_add ? xf : h_add ? acc : 32'd0;
  assign o_add_y     = pre_add ? i_negmean : h_add ? i_coeff : 32'd0;
  assign o_add_srdyi = state == PRE_ADD || state == H_ADD;
  assign o_mul_x     = (pre_mul || h_mul) ? acc : 32'd0;
  assign o_mul_y     = pre_mul ? i_invstd : h_mul ? xn : 32'd0;
  assign o_mul_srdyi = state == PRE_MUL || state == H_MUL;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = i_srdyi ? PRE_ADD : IDLE;
      PRE_ADD:   state_n = PRE_ADD_W;
      PRE_ADD_W: state_n = i_add_srdyo ? PRE_MUL : PRE_ADD_W;
      PRE_MUL:   state_n = PRE_MUL_W;
      PRE_MUL_W: state_n = i_mul_srdyo ? H_MUL : PRE_MUL_W;
      H_MUL:     state_n = H_MUL_W;
      H_MUL_W:   state_n = i_mul_srdyo ? H_ADD : H_MUL_W;
      H_ADD:     state_n = H_ADD_W;
      H_ADD_W:   state_n = i_add_srdyo ? (k == last ? DONE : H_MUL) : H_ADD_W;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      k      <= 3'd0;
      xf     <= 32'd0;
      acc    <= 32'd0;
      xn     <= 32'd0;
      o_y    <= 32'd0;
      o_sect <= 2'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && i_srdyi) begin
        xf     <= i_xf;
        o_sect <= dec;
      end
      if (state == PRE_ADD_W && i_add_srdyo) acc <= i_add_z;
      // o_cidx is 0 here, so i_coeff already presents coeff[0].
      if (state == PRE_MUL_W && i_mul_srdyo) begin
        xn  <= i_mul_z;
        acc <= i_coeff;
        k   <= 3'd1;
      end
      if (state == H_MUL_W && i_mul_srdyo) acc <= i_mul_z;
      if (state == H_ADD_W && i_add_srdyo) begin
        acc <= i_add_z;
        k   <= k == last ? 3'd0 : k + 3'd1;
        if (k == last) o_y <= i_add_z;
      end
    end
  end
endmodule

// File: doc/nlc_horner_ctrl.md
NLC_HORNER_CTRL -- requirements
Module: nlc_horner_ctrl

Interface
REQ-001 Parameter: NCOEF_S0, 7, coefficient count for section 0.
REQ-002 Parameter: NCOEF_S1, 6, coefficient count for section 1.
REQ-003 Parameter: NCOEF_S2, 6, coefficient count for section 2.
REQ-004 Parameter: NCOEF_S3, 7, coefficient count for section 3.
REQ-005 Parameter: XTHRESH, 44978, section breakpoint magnitude.
REQ-006 Port: i_clk  in  1  system clock; the block SHALL use one clock, all state changing on its rising edge.
REQ-007 Port: i_reset  in  1  reset; it SHALL be synchronous and active-high.
REQ-008 Ports: i_srdyi (in, 1) starts a job; i_xraw (in, 21, signed) raw ADC count; i_xf (in, 32) i_xraw already converted to smc float.
REQ-009 Ports: o_rdy (out, 1) idle and able to accept; o_srdyo (out, 1) one-cycle result valid; o_y (out, 32) result; o_sect (out, 2) decoded section of the current job.
REQ-010 Ports: o_cidx (out, 3) coefficient index; i_coeff (in, 32) combinational ROM data for (o_sect, o_cidx); i_negmean (in, 32) and i_invstd (in, 32) combinational per-section constants for o_sect.
REQ-011 Ports, multiplier: o_mul_x (out, 32), o_mul_y (out, 32), o_mul_srdyi (out, 1), i_mul_z (in, 32), i_mul_srdyo (in, 1). Adder: o_add_x, o_add_y, o_add_srdyi, i_add_z, i_add_srdyo, with the same widths.

Function
REQ-012 Accept: when i_srdyi=1 and o_rdy=1, the block SHALL latch i_xf and decode the section; i_srdyi while busy SHALL be ignored.
REQ-013 Section decode SHALL be: 0 if i_xraw <= -XTHRESH; 1 if -XTHRESH < i_xraw <= 0; 2 if 0 < i_xraw <= XTHRESH; 3 if i_xraw > XTHRESH. N = NCOEF_S<sect>.
REQ-014 Sequence: a = xf + negmean (adder); xn = a * invstd (multiplier); acc = coeff[0]; for k = 1..N-1: acc = acc*xn (multiplier), then acc = acc + coeff[k] (adder); o_y = acc.
REQ-015 States SHALL be IDLE, PRE_ADD, PRE_ADD_W, PRE_MUL, PRE_MUL_W, H_MUL, H_MUL_W, H_ADD, H_ADD_W, DONE.
REQ-016 Each issue state SHALL drive operands and pulse the matching srdyi for exactly one cycle, then move to its _W state.
REQ-017 Each _W state SHALL hold its operands stable, capture the unit's z on the cycle its srdyo=1, and advance on the next edge; the wait SHALL be unbounded.
REQ-018 A srdyo from a unit not being waited on, or arriving in IDLE/DONE, SHALL be ignored.
REQ-019 H_ADD_W with k = N-1 SHALL go to DONE; otherwise it SHALL increment k and go to H_MUL. o_cidx SHALL equal k throughout the Horner loop and 0 elsewhere.
REQ-020 DONE SHALL assert o_srdyo for one cycle with o_y = acc, then go to IDLE.
REQ-021 o_y SHALL hold its value until the next DONE.
REQ-022 o_rdy SHALL be 1 only in IDLE, so back-to-back jobs have a one-cycle gap minimum.
REQ-023 Latency: with both units at fixed latency L (srdyo L cycles after srdyi), o_srdyo SHALL assert exactly 2N(L+1)+1 cycles after the accepting edge.
REQ-024 The block SHALL NOT interpret smc float data; it SHALL only route 32-bit words.

Reset
REQ-025 i_reset=1 SHALL, on the edge, force IDLE, k=0, and all of o_y, o_srdyo, o_sect, o_cidx, o_mul_*, o_add_* to 0, with o_rdy=1 the following cycle.
REQ-026 Reset mid-job SHALL abandon the job with no o_srdyo; reset SHALL take priority over a simultaneous i_srdyi.

Verification
REQ-027 i_xraw=-50000 with a behavioral float model at L=3 -> o_sect=0, N=7, o_srdyo at cycle 57, o_y matches the reference Horner model.
REQ-028 i_xraw=0 then 1 (separate jobs) -> o_sect=1 then 2; N=6; o_srdyo at cycle 49 each.
REQ-029 i_xraw=44978 and 44979 -> o_sect=2 and 3 respectively; likewise -44978 -> 0 and -44977 -> 1.
REQ-030 i_srdyi pulsed every cycle during a job -> exactly one o_srdyo; o_y unchanged by the ignored requests.
REQ-031 Random unit latency 1-10 per op, plus spurious srdyo in IDLE -> o_srdyo count equals accepted jobs and each srdyi is a single-cycle pulse.
REQ-032 i_reset asserted in H_MUL_W with i_srdyi=1 in the same cycle -> no o_srdyo, all outputs 0 and o_rdy=1 next cycle, and a new job then completes correctly.
